// File: rtl/mult_exec_unit.sv
// Pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU) with CDB req/grant backpressure.
// Optional stall counter output o_stall_cnt is built when MULT_STALL_CNT_EN is defined.
module mult_exec_unit #(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 6,
    parameter int LATENCY = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_issue_valid,
    output logic             o_issue_ready,
    input  logic [1:0]       i_issue_op,
    input  logic [XLEN-1:0]  i_issue_rs1_data,
    input  logic [XLEN-1:0]  i_issue_rs2_data,
    input  logic [TAG_W-1:0] i_issue_rd_tag,
    input  logic             i_flush,
    output logic             o_cdb_valid,
    input  logic             i_cdb_grant,
    output logic [TAG_W-1:0] o_cdb_tag,
    output logic [XLEN-1:0]  o_cdb_result,
    output logic             o_cdb_branch,
    output logic             o_issue_done,
    output logic             o_busy
`ifdef MULT_STALL_CNT_EN
    ,
    output logic [31:0]      o_stall_cnt
`endif
);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_MULHU = 2'b11;

    logic                          w_a_sgn;
    logic                          w_b_sgn;
    logic [XLEN:0]                 w_a_ext;
    logic [XLEN:0]                 w_b_ext;
    logic [2*XLEN-1:0]             w_a_wide;
    logic [2*XLEN-1:0]             w_b_wide;
    logic [2*XLEN-1:0]             w_prod;
    logic [XLEN-1:0]               w_issue_res;

    logic [LATENCY-1:0]            r_vld;
    logic [LATENCY-1:0][TAG_W-1:0] r_tag;
    logic [LATENCY-1:0][XLEN-1:0]  r_res;
    logic                          r_done;

    logic [LATENCY-1:0]            w_adv;
    logic [LATENCY-1:0]            w_en;
    logic [LATENCY-1:0]            w_src_vld;
    logic [LATENCY-1:0][TAG_W-1:0] w_src_tag;
    logic [LATENCY-1:0][XLEN-1:0]  w_src_res;

    // Sign-extend operands to XLEN+1 bits per op, then to 2*XLEN so a plain
    // modular multiply yields the exact signed/unsigned product.
    always_comb begin
        w_a_sgn     = (i_issue_op != OP_MULHU);
        w_b_sgn     = (i_issue_op == OP_MUL) || (i_issue_op == OP_MULH);
        w_a_ext     = {w_a_sgn & i_issue_rs1_data[XLEN-1], i_issue_rs1_data};
        w_b_ext     = {w_b_sgn & i_issue_rs2_data[XLEN-1], i_issue_rs2_data};
        w_a_wide    = {{(XLEN-1){w_a_ext[XLEN]}}, w_a_ext};
        w_b_wide    = {{(XLEN-1){w_b_ext[XLEN]}}, w_b_ext};
        w_prod      = w_a_wide * w_b_wide;
        w_issue_res = (i_issue_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end

    // Advance chain: the last stage moves only on grant, earlier stages move
    // into a slot that is empty or vacating, so bubbles collapse.
    always_comb begin
        w_adv = '0;
        w_adv[LATENCY-1] = i_cdb_grant;
        for (int i = LATENCY - 2; i >= 0; i--) begin
            w_adv[i] = ~r_vld[i+1] | w_adv[i+1];
        end
        w_en = ~r_vld | w_adv;
    end

    always_comb begin
        w_src_vld    = '0;
        w_src_tag    = '0;
        w_src_res    = '0;
        w_src_vld[0] = i_issue_valid;
        w_src_tag[0] = i_issue_rd_tag;
        w_src_res[0] = w_issue_res;
        for (int i = 1; i < LATENCY; i++) begin
            w_src_vld[i] = r_vld[i-1];
            w_src_tag[i] = r_tag[i-1];
            w_src_res[i] = r_res[i-1];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld  <= '0;
            r_tag  <= '0;
            r_res  <= '0;
            r_done <= 1'b0;
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                if (w_en[i]) begin
                    r_vld[i] <= w_src_vld[i];
                    r_tag[i] <= w_src_tag[i];
                    r_res[i] <= w_src_res[i];
                end
            end
            // Flush overrides the moves above; a grant in this cycle still retires.
            if (i_flush) r_vld <= '0;
            r_done <= r_vld[LATENCY-1] & i_cdb_grant;
        end
    end

`ifdef MULT_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                                   r_stall_cnt <= '0;
        else if (r_vld[LATENCY-1] && !i_cdb_grant)   r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

    assign o_issue_ready = w_en[0];
    assign o_cdb_valid   = r_vld[LATENCY-1];
    assign o_cdb_tag     = r_tag[LATENCY-1];
    assign o_cdb_result  = r_res[LATENCY-1];
    assign o_cdb_branch  = 1'b0;
    assign o_issue_done  = r_done;
    assign o_busy        = |r_vld;

endmodule

// File: tb/tb_mult_exec_unit.sv
// Directed self-checking bench for mult_exec_unit (LATENCY=4); stall_cnt checks
// are compiled in only when MULT_STALL_CNT_EN is defined.
module tb_mult_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [1:0]  issue_op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [5:0]  rd_tag;
    logic        flush;
    logic        cdb_valid;
    logic        cdb_grant;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_result;
    logic        cdb_branch;
    logic        issue_done;
    logic        busy;
`ifdef MULT_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult_exec_unit #(.XLEN(32), .TAG_W(6), .LATENCY(4)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_issue_valid    (issue_valid),
        .o_issue_ready    (issue_ready),
        .i_issue_op       (issue_op),
        .i_issue_rs1_data (rs1),
        .i_issue_rs2_data (rs2),
        .i_issue_rd_tag   (rd_tag),
        .i_flush          (flush),
        .o_cdb_valid      (cdb_valid),
        .i_cdb_grant      (cdb_grant),
        .o_cdb_tag        (cdb_tag),
        .o_cdb_result     (cdb_result),
        .o_cdb_branch     (cdb_branch),
        .o_issue_done     (issue_done),
        .o_busy           (busy)
`ifdef MULT_STALL_CNT_EN
        ,
        .o_stall_cnt      (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stall(input string tag, input logic [31:0] exp);
`ifdef MULT_STALL_CNT_EN
        chk(tag, {32'd0, stall_cnt}, {32'd0, exp});
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] t);
        issue_valid = v;
        issue_op    = op;
        rs1         = a;
        rs2         = b;
        rd_tag      = t;
    endtask

    // Single op with grant held high: latency, tag, result and done pulse.
    task automatic run_one(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] t, input logic [31:0] exp, input string nm);
        int n;
        drive(1'b1, op, a, b, t);
        chk({nm, "_rdy"}, {63'd0, issue_ready}, 64'd1);
        step();
        issue_valid = 1'b0;
        n = 0;
        while (!cdb_valid && n < 12) begin
            step();
            n++;
        end
        chk({nm, "_lat"}, n, 3);
        chk({nm, "_tag"}, {58'd0, cdb_tag}, {58'd0, t});
        chk({nm, "_res"}, {32'd0, cdb_result}, {32'd0, exp});
        step();
        chk({nm, "_done"}, {63'd0, issue_done}, 64'd1);
        chk({nm, "_vld0"}, {63'd0, cdb_valid}, 64'd0);
        step();
        chk({nm, "_done0"}, {63'd0, issue_done}, 64'd0);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        flush = 1'b0;
        cdb_grant = 1'b0;
        drive(1'b0, 2'b00, 32'd0, 32'd0, 6'd0);
        #3;
        chk("rst_vld",    {63'd0, cdb_valid},   64'd0);
        chk("rst_busy",   {63'd0, busy},        64'd0);
        chk("rst_rdy",    {63'd0, issue_ready}, 64'd1);
        chk("rst_done",   {63'd0, issue_done},  64'd0);
        chk("rst_tag",    {58'd0, cdb_tag},     64'd0);
        chk("rst_res",    {32'd0, cdb_result},  64'd0);
        chk("rst_branch", {63'd0, cdb_branch},  64'd0);
        chk_stall("rst_stall", 32'd0);
        step();
        step();
        rst = 1'b0;
        cdb_grant = 1'b1;

        run_one(2'b00, 32'd7,        32'd6,        6'd5, 32'd42,        "mul7x6");
        run_one(2'b01, 32'h80000000, 32'h80000000, 6'd1, 32'h40000000,  "mulh_min");
        run_one(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd2, 32'hFFFFFFFE,  "mulhu_max");
        run_one(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd3, 32'hFFFFFFFF,  "mulhsu");
        run_one(2'b00, 32'hFFFFFFFF, 32'd2,        6'd4, 32'hFFFFFFFE,  "mul_wrap");
        run_one(2'b01, 32'hFFFFFFFF, 32'd1,        6'd6, 32'hFFFFFFFF,  "mulh_neg");
        run_one(2'b11, 32'hFFFFFFFF, 32'd1,        6'd8, 32'h00000000,  "mulhu_one");

        // Grant with nothing presented: no retire.
        step();
        chk("idle_grant_done", {63'd0, issue_done}, 64'd0);
        chk("idle_grant_busy", {63'd0, busy},       64'd0);
        chk_stall("idle_stall", 32'd0);

        // Back-to-back with grant held low: fill, stall, then drain in order.
        cdb_grant = 1'b0;
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 2'b00, 32'(j + 1), 32'd3, 6'(10 + j));
            chk("bb_rdy", {63'd0, issue_ready}, 64'd1);
            step();
        end
        drive(1'b1, 2'b00, 32'd5, 32'd3, 6'd14);
        chk("bb_full", {63'd0, issue_ready}, 64'd0);
        for (int k = 0; k < 3; k++) step();
        chk("bb_hold_rdy", {63'd0, issue_ready}, 64'd0);
        chk("bb_hold_tag", {58'd0, cdb_tag},     64'd10);
        chk("bb_hold_res", {32'd0, cdb_result},  64'd3);
        chk_stall("bb_stall", 32'd3);
        cdb_grant = 1'b1;
        #1;
        chk("bb_rel_rdy", {63'd0, issue_ready}, 64'd1);
        for (int j = 0; j < 6; j++) begin
            chk("bb_out_vld", {63'd0, cdb_valid},  64'd1);
            chk("bb_out_tag", {58'd0, cdb_tag},    64'(10 + j));
            chk("bb_out_res", {32'd0, cdb_result}, 64'(3 * (j + 1)));
            if (j > 0) chk("bb_out_done", {63'd0, issue_done}, 64'd1);
            step();
            if (j == 0) drive(1'b1, 2'b00, 32'd6, 32'd3, 6'd15);
            if (j == 1) issue_valid = 1'b0;
        end
        chk("bb_end_done", {63'd0, issue_done}, 64'd1);
        chk("bb_end_vld",  {63'd0, cdb_valid},  64'd0);
        chk("bb_end_busy", {63'd0, busy},       64'd0);
        chk_stall("bb_end_stall", 32'd3);

        // Flush with ops in stages 1 and 3; the stage-3 op is granted in the flush cycle.
        cdb_grant = 1'b0;
        drive(1'b1, 2'b00, 32'd2, 32'd2, 6'd20);
        step();
        issue_valid = 1'b0;
        step();
        drive(1'b1, 2'b00, 32'd3, 32'd3, 6'd21);
        step();
        issue_valid = 1'b0;
        step();
        chk("fl_pre_vld", {63'd0, cdb_valid}, 64'd1);
        chk("fl_pre_tag", {58'd0, cdb_tag},   64'd20);
        flush = 1'b1;
        cdb_grant = 1'b1;
        drive(1'b1, 2'b00, 32'd4, 32'd4, 6'd22);
        step();
        flush = 1'b0;
        issue_valid = 1'b0;
        chk("fl_busy", {63'd0, busy},       64'd0);
        chk("fl_vld",  {63'd0, cdb_valid},  64'd0);
        chk("fl_done", {63'd0, issue_done}, 64'd1);
        chk_stall("fl_stall", 32'd3);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (cdb_valid) seen++;
        end
        chk("fl_none", seen, 0);

        // Asynchronous reset with three ops in flight and a grant pending.
        cdb_grant = 1'b0;
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 2'b01, 32'(j), 32'd5, 6'(40 + j));
            step();
        end
        issue_valid = 1'b0;
        step();
        chk("ar_pre_vld", {63'd0, cdb_valid}, 64'd1);
        cdb_grant = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("ar_vld",  {63'd0, cdb_valid},   64'd0);
        chk("ar_busy", {63'd0, busy},        64'd0);
        chk("ar_rdy",  {63'd0, issue_ready}, 64'd1);
        chk("ar_tag",  {58'd0, cdb_tag},     64'd0);
        chk("ar_res",  {32'd0, cdb_result},  64'd0);
        chk("ar_done", {63'd0, issue_done},  64'd0);
        chk_stall("ar_stall", 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("ar_post_done", {63'd0, issue_done}, 64'd0);
        run_one(2'b00, 32'd3, 32'd3, 6'd7, 32'd9, "mul3x3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
